// File: rtl/i2f_pkg.sv
// Shared constants and result type for the int2float arbiter.
// Encodes the 11-bit integer to 3-bit exponent / 4-bit mantissa format.
package i2f_pkg;

    localparam int I2F_IN_W   = 11;
    localparam int I2F_EXP_W  = 3;
    localparam int I2F_MANT_W = 4;
    localparam int I2F_OUT_W  = I2F_EXP_W + I2F_MANT_W;

    typedef struct packed {
        logic [I2F_EXP_W-1:0]  exp;
        logic [I2F_MANT_W-1:0] mant;
    } i2f_result_t;

endpackage

// File: rtl/i2f_conv.sv
// Combinational integer-to-minifloat conversion.
// Values below 16 pass through as denormals; larger values keep their top four bits.
module i2f_conv
    import i2f_pkg::*;
(
    input  logic [I2F_IN_W-1:0] x,
    output i2f_result_t         y
);

    logic [I2F_EXP_W-1:0]  e;
    logic [I2F_MANT_W-1:0] mant;

    always_comb begin
        e = '0;
        // The highest set bit at or above bit 4 fixes the exponent; later hits override earlier ones.
        for (int b = I2F_MANT_W; b < I2F_IN_W; b++) begin
            if (x[b]) begin
                e = I2F_EXP_W'(b - (I2F_MANT_W - 1));
            end
        end
        mant   = I2F_MANT_W'(x >> e);
        y.exp  = e;
        y.mant = mant;
    end

endmodule

// File: rtl/int2float_arbiter.sv
// N-way arbiter feeding a two-stage int-to-float conversion pipeline.
// Define INT2FLOAT_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module int2float_arbiter
    import i2f_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*I2F_IN_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [I2F_OUT_W-1:0]   out_data,
    output logic [IDW-1:0]         out_id
);

    logic [I2F_IN_W-1:0] req_x [NREQ];

    logic                s1_valid_reg;
    logic [I2F_IN_W-1:0] s1_x_reg;
    logic [IDW-1:0]      s1_id_reg;

    logic                out_valid_reg;
    i2f_result_t         out_data_reg;
    logic [IDW-1:0]      out_id_reg;

    logic                s2_adv;
    logic                accept_en;
    logic                grant_valid;
    logic [IDW-1:0]      grant_id;
    logic                transfer;
    i2f_result_t         conv_y;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_x[gi] = req_data[I2F_IN_W*gi +: I2F_IN_W];
        end
    endgenerate

    assign s2_adv    = !out_valid_reg || out_ready;
    assign accept_en = !s1_valid_reg || s2_adv;
    assign transfer  = accept_en && grant_valid;

`ifdef INT2FLOAT_ARBITER_RR_EN
    logic [IDW-1:0] rr_ptr_reg;

    // Position k of the search order is requester (rr_ptr + k) mod NREQ; first hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_valid && req_valid[i] &&
                    ((int'(rr_ptr_reg) + k == i) || (int'(rr_ptr_reg) + k - NREQ == i))) begin
                    grant_valid = 1'b1;
                    grant_id    = IDW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (transfer) begin
            rr_ptr_reg <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`else
    // Scan downward so the lowest asserted index is the last, winning assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(k);
            end
        end
    end
`endif

    // Gated by rst_n so no accept is advertised while reset is held.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && transfer && (grant_id == IDW'(gi));
        end
    endgenerate

    i2f_conv u_conv (
        .x (s1_x_reg),
        .y (conv_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_x_reg      <= '0;
            s1_id_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_id_reg    <= '0;
        end else begin
            if (accept_en) begin
                s1_valid_reg <= grant_valid;
                if (grant_valid) begin
                    s1_x_reg  <= req_x[grant_id];
                    s1_id_reg <= grant_id;
                end
            end
            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= conv_y;
                    out_id_reg   <= s1_id_reg;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_id    = out_id_reg;

endmodule

// File: tb/tb_int2float_arbiter.sv
// Self-checking bench for int2float_arbiter (4 requesters) against a queue-based reference model.
// Arbitration expectations follow INT2FLOAT_ARBITER_RR_EN when it is defined.
module tb_int2float_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [43:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_data;
    logic [1:0]  out_id;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    typedef struct {
        logic [6:0] d;
        logic [1:0] id;
    } item_t;

    item_t      sb[$];
    logic [1:0] dlv_q[$];
    bit         m_out_v;
    int         m_ptr;

    int cx[5] = '{0, 15, 16, 100, 2047};
    int ce[5] = '{'h00, 'h0F, 'h18, 'h3C, 'h7F};

    int2float_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference conversion: exponent is how far x must shift right to fit in 4 bits.
    function automatic logic [6:0] ref_conv(input int x);
        int e;
        if (x < 16) return 7'(x);
        e = 0;
        while ((x >> (e + 4)) != 0) e++;
        return 7'(e * 16 + ((x >> e) % 16));
    endfunction

    function automatic int pick(input logic [3:0] v, input int ptr);
        int best;
        best = -1;
        for (int k = 0; k < 4; k++) begin
            if (best < 0 && v[(ptr + k) % 4]) best = (ptr + k) % 4;
        end
        return best;
    endfunction

    function automatic logic [43:0] rand_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[43:0];
    endfunction

    task automatic model_reset();
        sb.delete();
        m_out_v = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock cycle: check at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        int         g;
        bit         adv;
        bit         s1_full;
        bit         acc_en;
        logic [3:0] exp_rdy;
        item_t      it;
        @(negedge clk);
        adv     = !m_out_v || out_ready;
        s1_full = sb.size() > (m_out_v ? 1 : 0);
        acc_en  = !s1_full || adv;
        g       = acc_en ? pick(req_valid, m_ptr) : -1;
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_out_v));
        if (m_out_v) begin
            chk("out_data", 32'(out_data), 32'(sb[0].d));
            chk("out_id", 32'(out_id), 32'(sb[0].id));
        end
        n_acc += $countones(req_valid & req_ready);
        if (out_valid && out_ready) dlv_q.push_back(out_id);
        if (m_out_v && out_ready) void'(sb.pop_front());
        if (adv) m_out_v = s1_full;
        if (g >= 0) begin
            it.d  = ref_conv(int'(req_data[g*11 +: 11]));
            it.id = 2'(g);
            sb.push_back(it);
`ifdef INT2FLOAT_ARBITER_RR_EN
            m_ptr = (g + 1) % 4;
`endif
        end
        $display("cycle t=%0t valid=%b ready=%b out_v=%b out_d=%h out_id=%0d", $time, req_valid, req_ready,
                 out_valid, out_data, out_id);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_id", 32'(out_id), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = rand_data();
        out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        req_valid = 4'h0;

        // Conversion points, each sent alone to measure two-cycle latency.
        for (int i = 0; i < 5; i++) begin
            req_data        = rand_data();
            req_data[10:0]  = 11'(cx[i]);
            req_valid       = 4'b0001;
            step();
            req_valid = 4'b0000;
            chk("lat_t1_valid", 32'(out_valid), 0);
            step();
            chk("lat_t2_valid", 32'(out_valid), 1);
            chk("conv_data", 32'(out_data), 32'(ce[i]));
            chk("lat_id", 32'(out_id), 0);
            step();
            step();
        end

        // Arbitration order with continuous requests.
        do_reset();
        dlv_q.delete();
        out_ready = 1'b1;
`ifdef INT2FLOAT_ARBITER_RR_EN
        req_valid = 4'b1111;
`else
        req_valid = 4'b1010;
`endif
        repeat (12) begin
            req_data = rand_data();
            step();
        end
        chk("arb_count", 32'(dlv_q.size()), 10);
        for (int k = 0; k < dlv_q.size(); k++) begin
`ifdef INT2FLOAT_ARBITER_RR_EN
            chk("arb_rr_id", 32'(dlv_q[k]), 32'(k % 4));
`else
            chk("arb_fixed_id", 32'(dlv_q[k]), 1);
`endif
        end

        // Backpressure from an empty pipeline.
        req_valid = 4'h0;
        repeat (4) step();
        n_acc     = 0;
        req_valid = 4'hF;
        out_ready = 1'b0;
        repeat (5) begin
            req_data = rand_data();
            step();
        end
        chk("bp_accepts", 32'(n_acc), 2);
        chk("bp_req_ready", 32'(req_ready), 0);
        out_ready = 1'b1;
        req_valid = 4'h0;
        dlv_q.delete();
        repeat (4) step();
        chk("bp_drained", 32'(dlv_q.size()), 2);
        chk("bp_model_empty", 32'(sb.size()), 0);

        // Reset while both stages are full.
        out_ready = 1'b0;
        req_valid = 4'hF;
        repeat (3) begin
            req_data = rand_data();
            step();
        end
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 0);
        chk("rst_async_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        req_valid = 4'b0101;
        out_ready = 1'b1;
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'h0;
        repeat (3) step();

        // Randomized traffic with intermittent backpressure and withdrawn requests.
        repeat (400) begin
            req_valid = 4'($urandom());
            req_data  = rand_data();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 4'h0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("final_empty", 32'(sb.size()), 0);
        chk("final_out_valid", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
